// File: rtl/pll_recfg_seq.sv
// PLL reconfiguration sequencer: pushes N/M/C0/K settings through the reconfig-core
// management port, starts the update, then waits for the PLL to drop and regain lock.
module pll_recfg_seq #(
  parameter int LOCK_TIMEOUT = 65535,
  parameter int UNLOCK_WAIT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [17:0] n_cnt,
  input  logic [17:0] m_cnt,
  input  logic [17:0] c0_cnt,
  input  logic [31:0] k_frac,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, W_MODE, W_N, W_M, W_C0, W_K, W_START, WAIT_UNLOCK, WAIT_LOCK, FINISH
  } state_t;

  localparam logic [31:0] UNLOCK_LIM = UNLOCK_WAIT;
  localparam logic [31:0] LOCK_LIM   = LOCK_TIMEOUT;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        err_q, err_d;
  logic [17:0] n_q, m_q, c0_q;
  logic [31:0] k_q;
  logic        accept;

  logic [5:0]  addr_c;
  logic        wr_c;
  logic [31:0] data_c;

  assign accept  = (state_q == IDLE) && req;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q  <= '0;
      m_q  <= '0;
      c0_q <= '0;
      k_q  <= '0;
    end else if (accept) begin
      n_q  <= n_cnt;
      m_q  <= m_cnt;
      c0_q <= c0_cnt;
      k_q  <= k_frac;
    end
  end

  // Each write state holds its strobe/address/data until the core stops stalling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_c    = 1'b0;
    addr_c  = '0;
    data_c  = '0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = W_MODE;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      W_MODE: begin
        wr_c   = 1'b1;
        addr_c = 6'h00;
        data_c = 32'd0;
        if (!mgmt_waitrequest) state_d = W_N;
      end
      W_N: begin
        wr_c   = 1'b1;
        addr_c = 6'h03;
        data_c = {14'd0, n_q};
        if (!mgmt_waitrequest) state_d = W_M;
      end
      W_M: begin
        wr_c   = 1'b1;
        addr_c = 6'h04;
        data_c = {14'd0, m_q};
        if (!mgmt_waitrequest) state_d = W_C0;
      end
      W_C0: begin
        wr_c   = 1'b1;
        addr_c = 6'h05;
        data_c = {9'd0, 5'd0, c0_q};
        if (!mgmt_waitrequest) state_d = W_K;
      end
      W_K: begin
        wr_c   = 1'b1;
        addr_c = 6'h07;
        data_c = k_q;
        if (!mgmt_waitrequest) state_d = W_START;
      end
      W_START: begin
        wr_c   = 1'b1;
        addr_c = 6'h02;
        data_c = 32'd1;
        if (!mgmt_waitrequest) begin
          state_d = WAIT_UNLOCK;
          cnt_d   = '0;
        end
      end
      WAIT_UNLOCK: begin
        cnt_d = cnt_inc;
        if (!pll_locked || ({16'd0, cnt_inc} >= UNLOCK_LIM)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        cnt_d = cnt_inc;
        // Lock is checked first so a lock arriving on the timeout edge is not an error.
        if (pll_locked) begin
          state_d = FINISH;
          cnt_d   = '0;
        end else if ({16'd0, cnt_inc} >= LOCK_LIM) begin
          state_d = FINISH;
          err_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mgmt_write     = wr_c;
  assign mgmt_address   = addr_c;
  assign mgmt_writedata = data_c;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FINISH);
  assign err            = err_q;

endmodule

// File: tb/tb_pll_recfg_seq.sv
// Directed bench for pll_recfg_seq: register write order/data, stalls, lock timing,
// timeout error, ignored requests and mid-sequence reset.
module tb_pll_recfg_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [17:0] n_cnt, m_cnt, c0_cnt;
  logic [31:0] k_frac;
  logic        pll_locked;
  logic        mgmt_waitrequest;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        busy, done, err;

  int nvec = 0;
  int nerr = 0;

  pll_recfg_seq #(.LOCK_TIMEOUT(20), .UNLOCK_WAIT(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .n_cnt(n_cnt), .m_cnt(m_cnt), .c0_cnt(c0_cnt), .k_frac(k_frac),
    .pll_locked(pll_locked), .mgmt_waitrequest(mgmt_waitrequest),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_write"}, {31'd0, mgmt_write}, 32'd0);
    chk({tag, "_addr"}, {26'd0, mgmt_address}, 32'd0);
    chk({tag, "_data"}, mgmt_writedata, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  // Called at a negedge with the DUT in the write state; stalls for 'stall' cycles.
  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input int stall);
    for (int i = 0; i <= stall; i++) begin
      chk("wr_strobe", {31'd0, mgmt_write}, 32'd1);
      chk("wr_addr", {26'd0, mgmt_address}, {26'd0, a});
      chk("wr_data", mgmt_writedata, d);
      mgmt_waitrequest = (i < stall);
      @(negedge clk);
    end
    mgmt_waitrequest = 1'b0;
  endtask

  task automatic start_req(input logic [17:0] n, input logic [17:0] m,
                           input logic [17:0] c0, input logic [31:0] k);
    chk("pre_req_busy", {31'd0, busy}, 32'd0);
    n_cnt = n; m_cnt = m; c0_cnt = c0; k_frac = k;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("accept_err_clr", {31'd0, err}, 32'd0);
  endtask

  task automatic all_writes(input int stall, input logic [31:0] dn, input logic [31:0] dm,
                            input logic [31:0] dc, input logic [31:0] dk);
    do_write(6'h00, 32'd0, stall);
    do_write(6'h03, dn, stall);
    do_write(6'h04, dm, stall);
    do_write(6'h05, dc, stall);
    do_write(6'h07, dk, stall);
    do_write(6'h02, 32'd1, stall);
    chk("post_start_write", {31'd0, mgmt_write}, 32'd0);
    chk("post_start_busy", {31'd0, busy}, 32'd1);
  endtask

  // Counts negedges from the first wait-state cycle until done is seen.
  task automatic wait_done(input string tag, input int exp_cyc, input logic exp_err);
    int c = 0;
    while (!done && c < 64) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_cycles"}, c, exp_cyc);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; pll_locked = 1'b1; mgmt_waitrequest = 1'b0;
    n_cnt = '0; m_cnt = '0; c0_cnt = '0; k_frac = '0;
    repeat (2) @(negedge clk);
    chk_idle_outs("reset");
    chk("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal sequence: lock drops 3 cycles after START, returns 10 cycles later.
    start_req(18'h10101, 18'h00404, 18'h20504, 32'hD8ED_0000);
    all_writes(0, 32'h0001_0101, 32'h0000_0404, 32'h0002_0504, 32'hD8ED_0000);
    repeat (2) @(negedge clk);
    pll_locked = 1'b0;
    repeat (10) @(negedge clk);
    chk("nom_wait_done", {31'd0, done}, 32'd0);
    chk("nom_wait_busy", {31'd0, busy}, 32'd1);
    pll_locked = 1'b1;
    @(negedge clk);
    chk("nom_done", {31'd0, done}, 32'd1);
    chk("nom_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk_idle_outs("nom_after");

    // Four stall cycles on every write; lock never drops, so unlock wait times out at 8.
    start_req(18'h3FFFF, 18'h00001, 18'h2AA55, 32'h1234_5678);
    all_writes(4, 32'h0003_FFFF, 32'h0000_0001, 32'h0002_AA55, 32'h1234_5678);
    wait_done("stall", 9, 1'b0);

    // Lock never returns: error 20 cycles after entering WAIT_LOCK.
    start_req(18'h00101, 18'h00202, 18'h00303, 32'h0000_0001);
    pll_locked = 1'b0;
    all_writes(0, 32'h0000_0101, 32'h0000_0202, 32'h0000_0303, 32'h0000_0001);
    wait_done("timeout", 21, 1'b1);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);
    pll_locked = 1'b1;

    // Next request clears err; a request during W_M with new inputs is ignored.
    start_req(18'h00203, 18'h10000, 18'h00F0F, 32'hCAFE_BABE);
    do_write(6'h00, 32'd0, 0);
    do_write(6'h03, 32'h0000_0203, 0);
    n_cnt = 18'h3FFFF; m_cnt = 18'h3FFFF; c0_cnt = 18'h3FFFF; k_frac = 32'hFFFF_FFFF;
    req = 1'b1;
    do_write(6'h04, 32'h0001_0000, 0);
    req = 1'b0;
    do_write(6'h05, 32'h0000_0F0F, 0);
    do_write(6'h07, 32'hCAFE_BABE, 0);
    do_write(6'h02, 32'd1, 0);
    wait_done("ignore_req", 9, 1'b0);
    @(negedge clk);
    chk("no_queued_req", {31'd0, busy}, 32'd0);

    // Reset while W_C0 is stalled aborts at once.
    start_req(18'h00111, 18'h00222, 18'h00333, 32'h0000_0444);
    do_write(6'h00, 32'd0, 0);
    do_write(6'h03, 32'h0000_0111, 0);
    do_write(6'h04, 32'h0000_0222, 0);
    mgmt_waitrequest = 1'b1;
    chk("c0_stalled_write", {31'd0, mgmt_write}, 32'd1);
    chk("c0_stalled_addr", {26'd0, mgmt_address}, 32'h05);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_idle_outs("mid_reset");
    chk("mid_reset_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk_idle_outs("mid_reset_hold");
    rst = 1'b0;
    mgmt_waitrequest = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {31'd0, busy}, 32'd0);
    start_req(18'h10101, 18'h00404, 18'h20504, 32'hD8ED_0000);
    all_writes(0, 32'h0001_0101, 32'h0000_0404, 32'h0002_0504, 32'hD8ED_0000);
    wait_done("after_reset", 9, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pll_recfg_seq.md
PLL_RECFG_SEQ -- requirements
Module: pll_recfg_seq

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 65535, giving the maximum number of clk cycles spent in WAIT_LOCK before an error is flagged.
REQ-002 SHALL have parameter UNLOCK_WAIT, default 255, giving the maximum number of clk cycles spent in WAIT_UNLOCK.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; mgmt interface and all state are on it.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, 1 bit: reconfiguration request, sampled high for one cycle.
REQ-006 SHALL have ports n_cnt, m_cnt and c0_cnt, input, 18 bits each, in counter format: [17] odd-duty, [16] bypass, [15:8] high count, [7:0] low count.
REQ-007 SHALL have port k_frac, input, 32 bits: fractional division value.
REQ-008 SHALL have port pll_locked, input, 1 bit: PLL locked, already synchronous to clk.
REQ-009 SHALL have port mgmt_waitrequest, input, 1 bit: reconfig-core stall.
REQ-010 SHALL have port mgmt_address, output, 6 bits: register address.
REQ-011 SHALL have port mgmt_write, output, 1 bit: write strobe.
REQ-012 SHALL have port mgmt_writedata, output, 32 bits: write data.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a sequence completes.
REQ-015 SHALL have port err, output, 1 bit: sticky lock-timeout flag.

Function
REQ-016 SHALL use states IDLE, W_MODE, W_N, W_M, W_C0, W_K, W_START, WAIT_UNLOCK, WAIT_LOCK and FINISH.
REQ-017 In IDLE, req=1 SHALL latch n_cnt, m_cnt, c0_cnt and k_frac, clear err, and move to W_MODE on the next edge.
REQ-018 req outside IDLE SHALL be ignored: no latching, no queuing.
REQ-019 Each W_* state SHALL drive mgmt_write=1 with a stable address and data until a clk edge where mgmt_waitrequest=0; that edge SHALL complete the write and advance the state.
REQ-020 mgmt_write SHALL be 0 in all non-W_* states, with mgmt_address and mgmt_writedata driven to 0.
REQ-021 Register writes, in order:
- W_MODE: addr 0x00, data 0 (waitrequest mode).
- W_N: addr 0x03, data {14'b0, n}.
- W_M: addr 0x04, data {14'b0, m}.
- W_C0: addr 0x05, data {9'b0, 5'd0, c0} (counter select in bits [22:18] = 0).
- W_K: addr 0x07, data k.
- W_START: addr 0x02, data 1.
REQ-022 Minimum latency from req to done with waitrequest held at 0 and lock behaving ideally SHALL be 1 + 6 writes + unlock/lock wait + 1 cycles; each write takes at least one cycle.
REQ-023 WAIT_UNLOCK SHALL count cycles from 0 and go to WAIT_LOCK when pll_locked=0 or when the count reaches UNLOCK_WAIT, whichever comes first.
REQ-024 WAIT_LOCK SHALL count cycles from 0; pll_locked=1 SHALL go to FINISH.
REQ-025 In WAIT_LOCK, the count reaching LOCK_TIMEOUT with pll_locked still 0 SHALL set err=1 and go to FINISH.
REQ-026 If pll_locked=1 on the same edge that the count reaches LOCK_TIMEOUT, lock SHALL win and err SHALL stay 0.
REQ-027 FINISH SHALL assert done for exactly one cycle, then return to IDLE; err SHALL hold until the next accepted req or reset.
REQ-028 Counters SHALL saturate rather than wrap, and SHALL be 16 bits wide.
REQ-029 busy SHALL rise on the edge following req acceptance and fall on the edge leaving FINISH.

Reset
REQ-030 While rst=1: state=IDLE, busy=0, done=0, err=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, counters=0, latched values=0.
REQ-031 Reset asserted mid-sequence SHALL abort immediately, including abandoning any pending write, with no done pulse.

Verification
REQ-032 Waitrequest always 0, n=0x10101, m=0x00404, c0=0x20504, k=0xD8ED_0000, lock drops 3 cycles after START and returns 10 cycles later -> six writes in REQ-021 order with exact data, one done pulse, err=0.
REQ-033 Waitrequest held 1 for 4 cycles on each write -> mgmt_write, address and data stable across every stall, and each write completes exactly once.
REQ-034 LOCK_TIMEOUT=20, pll_locked never returns -> err=1 exactly 20 cycles after entering WAIT_LOCK, done pulses once, err clears on the next req.
REQ-035 pll_locked stays 1 throughout, UNLOCK_WAIT=8 -> WAIT_UNLOCK exits after 8 cycles, then FINISH the cycle after, err=0.
REQ-036 req pulsed during W_M with different inputs -> ignored; the original latched values are written.
REQ-037 rst asserted during W_C0 with waitrequest=1 -> all outputs 0 immediately, state IDLE; a subsequent req runs a complete sequence normally.
